score_bcd_sched: RTL and testbench

Shared, sequential binary-to-BCD conversion engine for the score HUD. It arbitrates one iterative double-dabble datapath between two requesters: the live score and the high score. Each requester's converted four-digit BCD result is held in a dedicated output register that feeds the hex/sprite digit renderer. The block replaces per-requester combinational converters with one 14-iteration engine, and adds a req/ack handshake plus saturation.

---
 rtl/score_bcd_sched.sv | 156 +++++++++++++++
 tb/tb_score_bcd_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_sched.sv
// Shared iterative double-dabble converter arbitrating live score and high score.
// Optional leading-zero blank masks are built when SCORE_BCD_BLANK_EN is defined.
module score_bcd_sched #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int SAT_VAL = 9999
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  score_req,
  input  logic [BIN_W-1:0]      score_bin,
  output logic                  score_ack,
  output logic [4*DIGITS-1:0]   score_bcd,
  input  logic                  hiscore_req,
  input  logic [BIN_W-1:0]      hiscore_bin,
  output logic                  hiscore_ack,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic                  busy,
  output logic [DIGITS-1:0]     score_blank,
  output logic [DIGITS-1:0]     hiscore_blank,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester holds req high until it sees its one-cycle ack;
  // its req is ignored by the arbiter during that ack cycle.

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  localparam int                CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0]  SAT_V = BIN_W'(SAT_VAL);

  state_t                    state_q, state_d;
  logic [BIN_W-1:0]          bin_q;
  logic [4*DIGITS-1:0]       bcd_q, bcd_adj;
  logic [4*DIGITS+BIN_W-1:0] shift_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      owner_hi_q, last_hi_q;
  logic                      score_ack_q, hiscore_ack_q;
  logic [4*DIGITS-1:0]       score_bcd_q, hiscore_bcd_q;
  logic                      s_pend, h_pend, grant, grant_hi, last_iter;
  logic [BIN_W-1:0]          grant_bin;

  assign s_pend = score_req & ~score_ack_q;
  assign h_pend = hiscore_req & ~hiscore_ack_q;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_pend || h_pend) state_d = CONV;
      CONV:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both pending: high score wins only if score was the previous grantee.
  always_comb begin
    busy      = (state_q != IDLE);
    grant     = (state_q == IDLE) && (s_pend || h_pend);
    grant_hi  = h_pend && (!s_pend || !last_hi_q);
    last_iter = (state_q == CONV) && (cnt_q == CNT_W'(BIN_W - 1));
    grant_bin = grant_hi ? hiscore_bin : score_bin;
    if (grant_bin > SAT_V) grant_bin = SAT_V;
  end

  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      else                         bcd_adj[4*d +: 4] = bcd_q[4*d +: 4];
    end
    shift_d = {bcd_adj[4*DIGITS-2:0], bin_q, 1'b0};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      owner_hi_q    <= 1'b0;
      last_hi_q     <= 1'b1;
      score_ack_q   <= 1'b0;
      hiscore_ack_q <= 1'b0;
      score_bcd_q   <= '0;
      hiscore_bcd_q <= '0;
    end else begin
      score_ack_q   <= 1'b0;
      hiscore_ack_q <= 1'b0;
      if (grant) begin
        bin_q      <= grant_bin;
        bcd_q      <= '0;
        cnt_q      <= '0;
        owner_hi_q <= grant_hi;
      end
      if (state_q == CONV) begin
        bcd_q <= shift_d[4*DIGITS+BIN_W-1:BIN_W];
        bin_q <= shift_d[BIN_W-1:0];
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == DONE) begin
        last_hi_q <= owner_hi_q;
        if (owner_hi_q) begin
          hiscore_bcd_q <= bcd_q;
          hiscore_ack_q <= 1'b1;
        end else begin
          score_bcd_q <= bcd_q;
          score_ack_q <= 1'b1;
        end
      end
    end
  end

`ifdef SCORE_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};
  logic [DIGITS-1:0] blank_d, score_blank_q, hiscore_blank_q;
  logic              all_zero;

  // A digit blanks only when it and every more significant digit are zero.
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (bcd_q[4*i +: 4] == 4'd0);
      blank_d[i] = all_zero;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_blank_q   <= BLANK_ZERO;
      hiscore_blank_q <= BLANK_ZERO;
    end else if (state_q == DONE) begin
      if (owner_hi_q) hiscore_blank_q <= blank_d;
      else            score_blank_q   <= blank_d;
    end
  end

  assign score_blank   = score_blank_q;
  assign hiscore_blank = hiscore_blank_q;
`else
  assign score_blank   = '0;
  assign hiscore_blank = '0;
`endif

  assign score_ack   = score_ack_q;
  assign hiscore_ack = hiscore_ack_q;
  assign score_bcd   = score_bcd_q;
  assign hiscore_bcd = hiscore_bcd_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_score_bcd_sched.sv
// Bench for score_bcd_sched: arithmetic reference model, per-cycle compare, directed scenarios.
// Expected blank masks follow SCORE_BCD_BLANK_EN.
module tb_score_bcd_sched;

  localparam int BIN_W = 14;
`ifdef SCORE_BCD_BLANK_EN
  localparam logic [3:0] BLANK_RST = 4'b1110;
`else
  localparam logic [3:0] BLANK_RST = 4'b0000;
`endif

  logic        Clk, Reset;
  logic        score_req, hiscore_req;
  logic [13:0] score_bin, hiscore_bin;
  logic        score_ack, hiscore_ack, busy;
  logic [15:0] score_bcd, hiscore_bcd;
  logic [3:0]  score_blank, hiscore_blank;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  score_bcd_sched dut (
    .Clk(Clk), .Reset(Reset),
    .score_req(score_req), .score_bin(score_bin),
    .score_ack(score_ack), .score_bcd(score_bcd),
    .hiscore_req(hiscore_req), .hiscore_bin(hiscore_bin),
    .hiscore_ack(hiscore_ack), .hiscore_bcd(hiscore_bcd),
    .busy(busy), .score_blank(score_blank), .hiscore_blank(hiscore_blank),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] blank_of(input int v);
    logic [3:0] b;
    b = 4'b0000;
`ifdef SCORE_BCD_BLANK_EN
    if (v < 10)   b[1] = 1'b1;
    if (v < 100)  b[2] = 1'b1;
    if (v < 1000) b[3] = 1'b1;
`endif
    return b;
  endfunction

  logic [16:0] exp_q[$];
  bit          model_on = 1'b0;
  int          m_cnt, m_val;
  bit          m_owner, m_last_hi, m_s_ack, m_h_ack, m_sp, m_hp;
  logic [15:0] m_s_bcd, m_h_bcd;
  logic [3:0]  m_s_blank, m_h_blank;

  // Engine modelled as a countdown: grant loads BIN_W+1, ack fires when it hits 0.
  always @(posedge Clk) begin
    if (Reset) begin
      model_on  = 1'b1;
      m_cnt     = 0;
      m_s_ack   = 1'b0;
      m_h_ack   = 1'b0;
      m_s_bcd   = 16'h0;
      m_h_bcd   = 16'h0;
      m_s_blank = BLANK_RST;
      m_h_blank = BLANK_RST;
      m_last_hi = 1'b1;
      exp_q.delete();
    end else if (model_on) begin
      m_sp    = score_req && !m_s_ack;
      m_hp    = hiscore_req && !m_h_ack;
      m_s_ack = 1'b0;
      m_h_ack = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_owner) begin
            m_h_bcd = to_bcd(m_val); m_h_blank = blank_of(m_val); m_h_ack = 1'b1;
          end else begin
            m_s_bcd = to_bcd(m_val); m_s_blank = blank_of(m_val); m_s_ack = 1'b1;
          end
          m_last_hi = m_owner;
          exp_q.push_back({m_owner, to_bcd(m_val)});
        end
      end else if (m_sp || m_hp) begin
        m_owner = m_hp && (!m_sp || !m_last_hi);
        m_val   = m_owner ? int'(hiscore_bin) : int'(score_bin);
        if (m_val > 9999) m_val = 9999;
        m_cnt   = BIN_W + 1;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  int n_s_acks = 0;
  int n_h_acks = 0;
  logic [16:0] sb_e;

  always @(negedge Clk) begin
    if (model_on) begin
      check("score_ack", score_ack, m_s_ack);
      check("hiscore_ack", hiscore_ack, m_h_ack);
      check("busy", busy, m_cnt != 0);
      check("score_bcd", score_bcd, m_s_bcd);
      check("hiscore_bcd", hiscore_bcd, m_h_bcd);
      check("score_blank", score_blank, m_s_blank);
      check("hiscore_blank", hiscore_blank, m_h_blank);
      if (score_ack) begin
        n_s_acks++;
        if (exp_q.size() == 0) check("sb_score_unexpected", score_ack, 1'b0);
        else begin sb_e = exp_q.pop_front(); check("sb_score", {1'b0, score_bcd}, sb_e); end
      end
      if (hiscore_ack) begin
        n_h_acks++;
        if (exp_q.size() == 0) check("sb_hiscore_unexpected", hiscore_ack, 1'b0);
        else begin sb_e = exp_q.pop_front(); check("sb_hiscore", {1'b1, hiscore_bcd}, sb_e); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_ack(input bit hi, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(hi ? hiscore_ack : score_ack) && n < 40);
    check("ack_seen", hi ? hiscore_ack : score_ack, 1'b1);
  endtask

  task automatic convert(input bit hi, input int val, input logic [15:0] exp_bcd,
                         input logic [3:0] exp_blank);
    int n;
    if (hi) begin hiscore_bin = 14'(val); hiscore_req = 1'b1; end
    else    begin score_bin   = 14'(val); score_req   = 1'b1; end
    wait_ack(hi, n);
    check("latency", n, 16);
    check("bcd_lit", hi ? hiscore_bcd : score_bcd, exp_bcd);
    check("blank_lit", hi ? hiscore_blank : score_blank, exp_blank);
    score_req   = 1'b0;
    hiscore_req = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- directed stimulus ----------------
  int n, h0, na;
  bit who[8];
  int at[8];

  initial begin
    Reset = 1'b1; score_req = 1'b0; hiscore_req = 1'b0;
    score_bin = '0; hiscore_bin = '0;
    repeat (2) @(negedge Clk);
    check("rst_score_bcd", score_bcd, 16'h0);
    check("rst_hiscore_bcd", hiscore_bcd, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {score_ack, hiscore_ack}, 2'b00);
    check("rst_blank", {score_blank, hiscore_blank}, {BLANK_RST, BLANK_RST});
    check("rst_state", dbg_state, 2'd0);
    Reset = 1'b0;

    // single request, fixed latency, other side untouched
    h0 = n_h_acks;
    score_bin = 14'd1234; score_req = 1'b1;
    wait_ack(1'b0, n);
    check("lat_1234", n, 16);
    check("bcd_1234", score_bcd, 16'h1234);
    check("model_1234", m_s_bcd, 16'h1234);
    check("hi_untouched", hiscore_bcd, 16'h0);
    check("busy_in_ack", busy, 1'b0);
    score_req = 1'b0;
    @(negedge Clk);
    check("ack_one_cycle", score_ack, 1'b0);
    check("no_hi_ack", n_h_acks, h0);

    // simultaneous requests: score first after reset, high score 16 cycles later
    do_reset();
    score_bin = 14'd57; hiscore_bin = 14'd9999;
    score_req = 1'b1; hiscore_req = 1'b1;
    wait_ack(1'b0, n);
    check("both_lat_s", n, 16);
    check("both_bcd_s", score_bcd, 16'h0057);
    check("model_57", m_s_bcd, 16'h0057);
    check("both_no_h_yet", hiscore_ack, 1'b0);
    score_req = 1'b0;
    wait_ack(1'b1, n);
    check("both_gap_h", n, 16);
    check("both_bcd_h", hiscore_bcd, 16'h9999);
    hiscore_req = 1'b0;
    @(negedge Clk);

    // saturation
    convert(1'b0, 16383, 16'h9999, 4'b0000);
    convert(1'b0, 10000, 16'h9999, 4'b0000);
    convert(1'b1, 16383, 16'h9999, 4'b0000);
    convert(1'b1, 9998, 16'h9998, 4'b0000);

    // both held for 64 cycles: strict alternation at 16-cycle spacing
    do_reset();
    score_bin = 14'd1; hiscore_bin = 14'd2;
    score_req = 1'b1; hiscore_req = 1'b1;
    na = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge Clk);
      if ((score_ack || hiscore_ack) && na < 8) begin
        who[na] = hiscore_ack;
        at[na]  = i;
        na++;
      end
    end
    score_req = 1'b0; hiscore_req = 1'b0;
    check("rr_count", na, 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_who", who[k], k % 2);
      check("rr_time", at[k], 16 * (k + 1));
    end
    check("rr_hi_bcd", hiscore_bcd, 16'h0002);
    repeat (2) @(negedge Clk);

    // reset during iteration 7 of 4321
    score_bin = 14'd4321; score_req = 1'b1;
    repeat (7) @(negedge Clk);
    check("mid_busy", busy, 1'b1);
    Reset = 1'b1; score_req = 1'b0;
    @(negedge Clk);
    check("abort_busy", busy, 1'b0);
    check("abort_ack", {score_ack, hiscore_ack}, 2'b00);
    check("abort_s_bcd", score_bcd, 16'h0);
    check("abort_h_bcd", hiscore_bcd, 16'h0);
    check("abort_blank", score_blank, BLANK_RST);
    Reset = 1'b0;
    convert(1'b0, 4321, 16'h4321, 4'b0000);

    // blank masks
`ifdef SCORE_BCD_BLANK_EN
    convert(1'b0, 0,    16'h0000, 4'b1110);
    convert(1'b0, 42,   16'h0042, 4'b1100);
    convert(1'b0, 1000, 16'h1000, 4'b0000);
    convert(1'b1, 42,   16'h0042, 4'b1100);
    convert(1'b1, 7,    16'h0007, 4'b1110);
`else
    convert(1'b0, 0,    16'h0000, 4'b0000);
    convert(1'b0, 42,   16'h0042, 4'b0000);
    convert(1'b0, 1000, 16'h1000, 4'b0000);
    convert(1'b1, 42,   16'h0042, 4'b0000);
    convert(1'b1, 7,    16'h0007, 4'b0000);
`endif

    repeat (3) @(negedge Clk);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
